// File: rtl/imem_fetch_unit.sv
// Cell-array instruction memory: assembles CELLS_PER_INSTR cells into one instruction
// behind valid/ready handshakes. Define IMEM_BOUNDS_CHK_EN to flag out-of-range or misaligned fetches.
//
// state | meaning
// IDLE  | ready for a request
// READ  | shifting one cell per cycle into the accumulator
// RESP  | instruction presented, waiting for resp_ready
module imem_fetch_unit #(
  parameter int CELL_W          = 4,
  parameter int CELLS_PER_INSTR = 4,
  parameter int DEPTH           = 64,
  parameter int ADDR_W          = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              prog_we,
  input  logic [ADDR_W-1:0]                 prog_addr,
  input  logic [CELL_W-1:0]                 prog_data,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_W-1:0]                 req_addr,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [CELL_W*CELLS_PER_INSTR-1:0] resp_instr,
  output logic                              resp_err,
  output logic                              busy
);

  localparam int INSTR_W = CELL_W * CELLS_PER_INSTR;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = (CELLS_PER_INSTR > 1) ? $clog2(CELLS_PER_INSTR) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [CELL_W-1:0]  mem [DEPTH];
  logic [1:0]         state;
  logic [IDX_W-1:0]   base;
  logic [CNT_W-1:0]   cnt;
  logic [INSTR_W-1:0] acc;
  logic [IDX_W-1:0]   rd_idx;
  logic [INSTR_W-1:0] acc_next;
  logic               abort_read;
  logic               unused_prog_hi;

  assign unused_prog_hi = ^prog_addr[ADDR_W-1:IDX_W];

  // Read port sees the pre-write value when a program write hits the same cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (prog_we) begin
      mem[prog_addr[IDX_W-1:0]] <= prog_data;
    end
  end

  assign rd_idx   = base + IDX_W'(cnt);
  assign acc_next = {acc[INSTR_W-CELL_W-1:0], mem[rd_idx]};

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

`ifdef IMEM_BOUNDS_CHK_EN
  logic addr_bad;
  logic err_pend;

  assign addr_bad = (req_addr > ADDR_W'(DEPTH - CELLS_PER_INSTR)) ||
                    ((req_addr % ADDR_W'(CELLS_PER_INSTR)) != '0);
  assign abort_read = err_pend;

  // A bad request still spends one READ cycle so the error arrives one edge after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend <= 1'b0;
      resp_err <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      err_pend <= addr_bad;
    end else if (state == READ) begin
      resp_err <= err_pend;
    end
  end
`else
  logic unused_req_hi;

  assign unused_req_hi = ^req_addr[ADDR_W-1:IDX_W];
  assign abort_read    = 1'b0;
  assign resp_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      cnt        <= '0;
      acc        <= '0;
      resp_instr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            base  <= req_addr[IDX_W-1:0];
            acc   <= '0;
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (abort_read) begin
            resp_instr <= '0;
            state      <= RESP;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CELLS_PER_INSTR - 1)) begin
              resp_instr <= acc_next;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: vector table of fetches plus backpressure,
// write/read collision and mid-fetch reset sequences. Honours IMEM_BOUNDS_CHK_EN.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [15:0] prog_addr = '0;
  logic [3:0]  prog_data = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_instr;
  logic        resp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  imem_fetch_unit #(.CELL_W(4), .CELLS_PER_INSTR(4), .DEPTH(64), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] cells;
    logic [15:0] instr;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input logic [15:0] a, input logic [3:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic start_req(input string name, input logic [15:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_resp(input string name, input int exp_lat);
    int n = 0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic finish_resp(input string name, input logic [15:0] held);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({name, "_ready_back"}, 32'(req_ready), 32'd1);
    check({name, "_instr_held"}, 32'(resp_instr), 32'(held));
  endtask

  task automatic fetch(input string name, input logic [15:0] a, input logic [15:0] exp_instr,
                       input logic exp_err, input int exp_lat);
    start_req(name, a);
    wait_resp(name, exp_lat);
    check({name, "_instr"}, 32'(resp_instr), 32'(exp_instr));
    check({name, "_err"}, 32'(resp_err), 32'(exp_err));
    finish_resp(name, exp_instr);
  endtask

  initial begin
    vecs[0] = '{addr: 16'd8,     wr: 1'b1, cells: 16'h3709, instr: 16'h3709, err: 1'b0, lat: 4};
    vecs[1] = '{addr: 16'd62,    wr: 1'b1, cells: 16'h1234, instr: 16'h1234, err: 1'b0, lat: 4};
    vecs[2] = '{addr: 16'h0104,  wr: 1'b1, cells: 16'hABCD, instr: 16'hABCD, err: 1'b0, lat: 4};
    vecs[3] = '{addr: 16'd32,    wr: 1'b1, cells: 16'hF0E1, instr: 16'hF0E1, err: 1'b0, lat: 4};
    vecs[4] = '{addr: 16'd10,    wr: 1'b1, cells: 16'h1111, instr: 16'h1111, err: 1'b0, lat: 4};
    vecs[5] = '{addr: 16'd40,    wr: 1'b0, cells: 16'h0000, instr: 16'h0000, err: 1'b0, lat: 4};
`ifdef IMEM_BOUNDS_CHK_EN
    foreach (vecs[i]) begin
      if (vecs[i].addr > 16'd60 || vecs[i].addr[1:0] != 2'b00) begin
        vecs[i].instr = 16'h0000;
        vecs[i].err   = 1'b1;
        vecs[i].lat   = 1;
      end
    end
`endif

    // Reset, with a program write that must be ignored (cell 40 stays 0).
    rst       = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 16'd40;
    prog_data = 4'h7;
    step();
    step();
    rst     = 1'b0;
    prog_we = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_instr", 32'(resp_instr), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) begin
        for (int k = 0; k < 4; k++) begin
          logic [15:0] c;
          c = vecs[i].cells;
          write_cell(vecs[i].addr + 16'(k), c[15 - 4*k -: 4]);
        end
      end
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err, vecs[i].lat);
    end

    // Backpressure: response held while a competing request is offered.
    write_cell(16'd12, 4'hC);
    write_cell(16'd13, 4'hA);
    write_cell(16'd14, 4'hF);
    write_cell(16'd15, 4'hE);
    start_req("bp", 16'd12);
    wait_resp("bp", 4);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 16'd8;
      check($sformatf("bp_valid%0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("bp_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
      check($sformatf("bp_instr%0d", i), 32'(resp_instr), 32'hCAFE);
      step();
    end
    req_valid = 1'b0;
    finish_resp("bp", 16'hCAFE);

    // Collision: cell 20 rewritten in the very cycle it is read.
    write_cell(16'd20, 4'hA);
    write_cell(16'd21, 4'h1);
    write_cell(16'd22, 4'h2);
    write_cell(16'd23, 4'h3);
    start_req("coll", 16'd20);
    prog_we   = 1'b1;
    prog_addr = 16'd20;
    prog_data = 4'h5;
    step();
    prog_we = 1'b0;
    wait_resp("coll", 3);
    check("coll_instr", 32'(resp_instr), 32'hA123);
    finish_resp("coll", 16'hA123);
    fetch("coll_refetch", 16'd20, 16'h5123, 1'b0, 4);

    // Reset in the second READ cycle aborts the fetch and clears memory.
    write_cell(16'd8, 4'h3);
    write_cell(16'd9, 4'h7);
    write_cell(16'd10, 4'h0);
    write_cell(16'd11, 4'h9);
    start_req("mid_rst", 16'd8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_instr", 32'(resp_instr), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    fetch("mid_rst_clear", 16'd8, 16'h0000, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
